// File: rtl/zc_freq_est_pkg.sv
// Shared definitions for the zero-crossing frequency estimator and the PLL it feeds.
// Holds the FSM encoding and the default widths both sides must agree on.
package zc_freq_est_pkg;

  localparam int unsigned FW_DEF        = 48;
  localparam int unsigned DW_DEF        = 10;
  localparam int unsigned NPER_LOG2_DEF = 2;
  localparam int unsigned DEC_LOG2_DEF  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Exponent of the divide numerator: FTW = 2^(fw+nper-dec) / samples_per_window.
  function automatic int unsigned ftw_shift(input int unsigned fw,
                                            input int unsigned nper,
                                            input int unsigned dec);
    return fw + nper - dec;
  endfunction

endpackage

// File: rtl/serial_udiv.sv
// Restoring unsigned divider, one quotient bit per clock, Q_W iterations per start.
// The upper DVS_W bits of the dividend must be smaller than the divisor.
module serial_udiv
  import zc_freq_est_pkg::*;
#(
  parameter int unsigned Q_W   = FW_DEF,
  parameter int unsigned DVS_W = 24
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   start,
  input  logic [Q_W+DVS_W-1:0]   dividend,
  input  logic [DVS_W-1:0]       divisor,
  output logic                   done,
  output logic [Q_W-1:0]         quotient
);

  localparam int unsigned CW = $clog2(Q_W + 1);

  logic [DVS_W-1:0] r_rem;
  logic [DVS_W-1:0] r_dvs;
  logic [Q_W-1:0]   r_quo;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [DVS_W:0]   w_trial;
  logic             w_ge;
  logic [DVS_W-1:0] w_diff;

  // r_quo doubles as the shift register for the low dividend bits and the quotient.
  assign w_trial = {r_rem, r_quo[Q_W-1]};
  assign w_ge    = w_trial >= {1'b0, r_dvs};
  assign w_diff  = w_trial[DVS_W-1:0] - r_dvs;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rem  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem <= dividend[Q_W +: DVS_W];
        r_quo <= dividend[Q_W-1:0];
        r_dvs <= divisor;
        r_cnt <= CW'(Q_W);
      end else if (r_cnt != '0) begin
        r_rem  <= w_ge ? w_diff : w_trial[DVS_W-1:0];
        r_quo  <= {r_quo[Q_W-2:0], w_ge};
        r_cnt  <= r_cnt - CW'(1);
        r_done <= (r_cnt == CW'(1));
      end
    end
  end

  assign done     = r_done;
  assign quotient = r_quo;

endmodule

// File: rtl/zc_freq_est.sv
// Zero-crossing frequency estimator: Schmitt-trigger edge detection, sample counting over
// 2^NPER_LOG2 periods, and a serial divide producing a PLL tuning word.
module zc_freq_est
  import zc_freq_est_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned FW        = FW_DEF,
  parameter int unsigned NPER_LOG2 = NPER_LOG2_DEF,
  parameter int          HYST      = 8,
  parameter int unsigned DEC_LOG2  = DEC_LOG2_DEF,
  parameter int unsigned CNT_W     = 24
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] data_in,
  output logic [FW-1:0]        fre_out,
  output logic                 fre_valid,
  output logic                 locked,
  output logic                 busy
);

  localparam int unsigned DVD_W = FW + CNT_W;
  localparam int unsigned EW    = NPER_LOG2 + 1;
  localparam int unsigned K     = ftw_shift(FW, NPER_LOG2, DEC_LOG2);

  localparam logic [DVD_W-1:0]     LP_DIVIDEND = DVD_W'(1) << K;
  localparam logic [EW-1:0]        LP_NEDGE    = EW'(1) << NPER_LOG2;
  localparam logic signed [DW-1:0] LP_HI       = DW'(HYST);
  localparam logic signed [DW-1:0] LP_LO       = DW'(-HYST);

  state_t r_state;
  state_t w_state_nxt;

  logic             r_schmitt;
  logic [CNT_W-1:0] r_s;
  logic [EW-1:0]    r_edges;
  logic [CNT_W-1:0] r_divisor;
  logic             r_start;
  logic             r_busy;
  logic             r_kill;
  logic             r_fre_valid;
  logic             r_locked;
  logic [FW-1:0]    r_fre_out;

  logic             w_above;
  logic             w_below;
  logic             w_rise;
  logic [CNT_W-1:0] w_s_inc;
  logic             w_s_top;
  logic             w_last_edge;
  logic             w_s_clr;
  logic             w_s_en;
  logic             w_edge_en;
  logic             w_win_close;
  logic             w_timeout;
  logic             w_start_div;
  logic             w_div_done;
  logic [FW-1:0]    w_quot;

  assign w_above     = data_in > LP_HI;
  assign w_below     = data_in < LP_LO;
  assign w_rise      = din_valid & ~r_schmitt & w_above;
  assign w_s_inc     = r_s + CNT_W'(1);
  assign w_s_top     = &w_s_inc;
  assign w_last_edge = (r_edges + EW'(1)) == LP_NEDGE;
  // A window closing while the divider is still busy is dropped, but its counter restarts.
  assign w_start_div = w_win_close & ~r_busy;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_clr     = 1'b0;
    w_s_en      = 1'b0;
    w_edge_en   = 1'b0;
    w_win_close = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_s_clr     = 1'b1;
          w_state_nxt = ST_MEAS;
        end
      end
      ST_MEAS, ST_DIV: begin
        if ((r_state == ST_DIV) && w_div_done) begin
          w_state_nxt = ST_MEAS;
        end
        // Timeout outranks an edge arriving on the same sample.
        if (din_valid) begin
          if (w_s_top) begin
            w_timeout   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (w_rise && w_last_edge) begin
            w_win_close = 1'b1;
            if (!r_busy) begin
              w_state_nxt = ST_DIV;
            end
          end else begin
            w_s_en    = 1'b1;
            w_edge_en = w_rise;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Schmitt state and window counters.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_schmitt <= 1'b0;
      r_s       <= '0;
      r_edges   <= '0;
    end else begin
      if (din_valid && w_above) begin
        r_schmitt <= 1'b1;
      end else if (din_valid && w_below) begin
        r_schmitt <= 1'b0;
      end
      if (w_s_clr || w_win_close || w_timeout) begin
        r_s     <= '0;
        r_edges <= '0;
      end else begin
        if (w_s_en) begin
          r_s <= w_s_inc;
        end
        if (w_edge_en) begin
          r_edges <= r_edges + EW'(1);
        end
      end
    end
  end

  // Divider handshake, result capture and lock tracking.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_divisor   <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_kill      <= 1'b0;
      r_fre_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_fre_out   <= '0;
    end else begin
      r_start     <= w_start_div;
      r_fre_valid <= w_div_done;
      if (w_start_div) begin
        r_divisor <= w_s_inc;
      end
      if (w_start_div) begin
        r_busy <= 1'b1;
      end else if (r_fre_valid) begin
        r_busy <= 1'b0;
      end
      if (w_start_div) begin
        r_kill <= 1'b0;
      end else if (w_timeout) begin
        r_kill <= 1'b1;
      end
      if (w_div_done) begin
        r_fre_out <= w_quot;
      end
      if (w_timeout) begin
        r_locked <= 1'b0;
      end else if (w_div_done && !r_kill) begin
        r_locked <= 1'b1;
      end
    end
  end

  serial_udiv #(
    .Q_W   (FW),
    .DVS_W (CNT_W)
  ) u_div (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (r_start),
    .dividend (LP_DIVIDEND),
    .divisor  (r_divisor),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  assign fre_out   = r_fre_out;
  assign fre_valid = r_fre_valid;
  assign locked    = r_locked;
  assign busy      = r_busy;

endmodule

// File: tb/tb_zc_freq_est.sv
// Scoreboard bench for zc_freq_est: a sample-level reference model predicts each tuning
// word, its cycle, and each loss of lock; a monitor compares whatever the DUT emits.
module tb_zc_freq_est;

  localparam int DW        = 10;
  localparam int FW        = 48;
  localparam int NPER_LOG2 = 2;
  localparam int HYST      = 8;
  localparam int DEC_LOG2  = 0;
  localparam int CNT_W     = 12;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst;
  logic                 din_valid;
  logic signed [DW-1:0] data_in;
  logic [FW-1:0]        fre_out;
  logic                 fre_valid;
  logic                 locked;
  logic                 busy;

  always #5 sys_clk = ~sys_clk;

  zc_freq_est #(
    .DW(DW), .FW(FW), .NPER_LOG2(NPER_LOG2), .HYST(HYST), .DEC_LOG2(DEC_LOG2), .CNT_W(CNT_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .din_valid (din_valid),
    .data_in   (data_in),
    .fre_out   (fre_out),
    .fre_valid (fre_valid),
    .locked    (locked),
    .busy      (busy)
  );

  typedef struct {
    int              cyc;
    longint unsigned fre;
  } exp_t;

  exp_t exp_q[$];
  int   fall_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic rst_q   = 1'b1;

  always @(posedge sys_clk) begin
    cyc   <= cyc + 1;
    rst_q <= sys_rst;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model state: sample indices count valid samples only.
  bit              m_sch;
  bit              m_meas;
  int              m_n;
  int              m_start;
  int              m_edges;
  int              m_busy_end;
  bit              m_locked;
  longint unsigned m_last_fre;

  task automatic model_reset();
    m_sch      = 0;
    m_meas     = 0;
    m_n        = 0;
    m_start    = 0;
    m_edges    = 0;
    m_busy_end = -1000;
    m_locked   = 0;
    m_last_fre = 0;
    exp_q.delete();
    fall_q.delete();
  endtask

  task automatic model_sample(input int c, input int x);
    bit rise = 0;
    int len;
    longint unsigned fre;
    if (x > HYST) begin
      rise  = !m_sch;
      m_sch = 1;
    end else if (x < -HYST) begin
      m_sch = 0;
    end
    if (!m_meas) begin
      if (rise) begin
        m_meas  = 1;
        m_start = m_n;
        m_edges = 0;
      end
    end else begin
      len = m_n - m_start;
      if (len == (1 << CNT_W) - 1) begin
        m_meas = 0;
        if (m_locked) fall_q.push_back(c);
        m_locked = 0;
      end else if (rise) begin
        m_edges++;
        if (m_edges == (1 << NPER_LOG2)) begin
          if (c > m_busy_end) begin
            fre = (64'd1 << (FW + NPER_LOG2 - DEC_LOG2)) / longint'(len);
            exp_q.push_back('{c + FW + 2, fre});
            m_busy_end = c + FW + 3;
            m_locked   = 1;
            m_last_fre = fre;
          end
          m_start = m_n;
          m_edges = 0;
        end
      end
    end
    m_n++;
  endtask

  task automatic drive(input bit v, input int x);
    din_valid = v;
    data_in   = DW'(x);
    if (v) model_sample(cyc + 1, x);
    @(posedge sys_clk);
    #1;
  endtask

  function automatic bit want_valid(input int vmode);
    if (vmode == 1) return (cyc % 2) == 0;
    if (vmode == 2) return $urandom_range(0, 2) != 0;
    return 1'b1;
  endfunction

  // Square wave of nsamp valid samples; invalid cycles carry junk that must be ignored.
  task automatic run_square(input int half, input int amp, input int nsamp,
                            input int vmode, input int noise);
    int ph = 0;
    int k  = 0;
    int val;
    while (k < nsamp) begin
      if (want_valid(vmode)) begin
        val = (ph < half) ? amp : -amp;
        if (noise > 0) val += int'($urandom_range(0, 2 * noise)) - noise;
        drive(1'b1, val);
        ph = (ph + 1) % (2 * half);
        k++;
      end else begin
        drive(1'b0, int'($urandom_range(0, 1023)) - 512);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every fre_valid and every loss of lock.
  bit   lk_prev = 0;
  exp_t e;
  int   f;
  always @(negedge sys_clk) begin
    if (rst_q) begin
      lk_prev = 0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("missed_fre_valid", 64'(cyc), 64'(e.cyc));
      end
      if (fre_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fre_valid", 64'(fre_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("fre_valid_cycle", 64'(cyc), 64'(e.cyc));
          check("fre_out", 64'(fre_out), e.fre);
          check("locked_at_valid", 64'(locked), 64'd1);
          check("busy_at_valid", 64'(busy), 64'd1);
        end
      end
      if (lk_prev && !locked) begin
        if (fall_q.size() == 0) begin
          check("unexpected_lock_loss", 64'(locked), 64'd1);
        end else begin
          f = fall_q.pop_front();
          check("lock_loss_cycle", 64'(cyc), 64'(f));
        end
      end
      lk_prev = locked;
    end
  end

  int ph;
  int found;

  initial begin
    sys_rst   = 1'b1;
    din_valid = 1'b0;
    data_in   = '0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_fre_out", 64'(fre_out), 64'd0);
    check("rst_fre_valid", 64'(fre_valid), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    sys_rst = 1'b0;

    run_square(32, 100, 1300, 0, 0);
    run_square(500, 100, 13100, 0, 0);
    run_square(32, 100, 1300, 1, 0);
    repeat (6) begin
      run_square(int'($urandom_range(1, 80)), int'($urandom_range(12, 500)), 1500,
                 int'($urandom_range(0, 2)), 3);
    end

    // Lock, then stay inside the hysteresis band until the window times out.
    run_square(32, 100, 600, 0, 0);
    repeat (4500) drive(1'b1, int'($urandom_range(0, 16)) - 8);
    check("hold_fre_out_after_timeout", 64'(fre_out), m_last_fre);
    check("locked_after_timeout", 64'(locked), 64'd0);

    // Reset ten cycles into a divide.
    ph    = 0;
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      drive(1'b1, (ph < 32) ? 100 : -100);
      ph = (ph + 1) % 64;
      if (exp_q.size() > 0) found = 1;
    end
    check("rst_window_found", 64'(found), 64'd1);
    repeat (10) begin
      drive(1'b1, (ph < 32) ? 100 : -100);
      ph = (ph + 1) % 64;
    end
    sys_rst   = 1'b1;
    din_valid = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    model_reset();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_fre_out", 64'(fre_out), 64'd0);
    check("midrst_locked", 64'(locked), 64'd0);
    check("midrst_fre_valid", 64'(fre_valid), 64'd0);
    run_square(32, 100, 1400, 0, 0);
    check("relock", 64'(locked), 64'(m_locked));

    din_valid = 1'b0;
    repeat (60) @(posedge sys_clk);
    #1;
    check("pending_fre_events", 64'(exp_q.size()), 64'd0);
    check("pending_lock_events", 64'(fall_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
